lap_stopwatch: RTL and testbench
================================

// Module: lap_stopwatch
// PURPOSE
//  Parametrised next-generation stopwatch for the mode-multiplexed display.
//  Counts MM:SS.cc from a clk prescaler and supports start/pause/reset.
//  Captures split (lap) times into a circular buffer that can be browsed while paused.
//  Drives six 7-segment digit codes through bcd2seven, plus raw BCD for checking.
// PARAMETERS
//  TICK_DIV   10000  clk cycles per centisecond (>=1)
//  LAP_DEPTH  4      lap buffer entries (>=1); oldest is overwritten when full
//  MIN_MAX    100    minute modulus (1..100); minutes count 0..MIN_MAX-1
// PORTS
//  clk      in   1          system clock, all state on posedge
//  rst_n    in   1          asynchronous reset, active low
//  mode     in   1          1 = stopwatch selected; 0 = held cleared
//  enter    in   1          level button: start/pause; exit recall
//  esc      in   1          level button: lap (RUN), clear (PAUSE), exit recall
//  up       in   1          level button: recall / browse older lap
//  down     in   1          level button: recall / browse newer lap
//  bcd      out  24         {m1,m0,s1,s0,c1,c0}, 4b BCD each, shown value
//  out      out  48         bcd2seven codes, digit0 in [7:0] .. digit5 in [47:40]
//  norm     out  1          1 = live time shown, 0 = lap shown
//  running  out  1          1 while in RUN
//  lap_cnt  out  $clog2(LAP_DEPTH+1)  stored laps, saturates at LAP_DEPTH
//  ovf      out  1          sticky: time wrapped past (MIN_MAX-1):59.99
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE, time/prescaler/laps/lap_cnt/ovf=0, norm=1,
//   running=0, bcd=0, out=codes of six zeros. Any mid-operation reset clears everything.
//  Buttons: one prev-register per button; event = input high && prev low at a posedge.
//   Max one event per cycle, priority enter > esc > up > down; lower ones are dropped.
//   A held button yields a single event.
//  mode=0: state IDLE, time, prescaler, laps, lap_cnt and ovf cleared; events ignored.
//   Prev-registers still track, so a button held across a mode switch gives no event.
//  States/transitions (take effect at the event posedge):
//   IDLE  : enter->RUN; esc/up/down no-op
//   RUN   : enter->PAUSE; esc->capture lap, stay RUN
//   PAUSE : enter->RUN; esc->IDLE (time, prescaler, laps, lap_cnt, ovf cleared);
//           up/down->RECALL if lap_cnt>0, else no-op
//   RECALL: up->idx+1 sat lap_cnt-1; down->idx-1 sat 0; enter/esc->PAUSE (no start)
//  Counting (RUN only): prescaler 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0 and
//   cs increments. Carry chain: cs 0..99, sec 0..59, min 0..MIN_MAX-1.
//   Full wrap returns all to 0 and sets ovf. First cs tick occurs TICK_DIV cycles after
//   the enter posedge. PAUSE freezes prescaler (partial count kept on resume).
//  Lap capture: stores time value present before that posedge's increment.
//   Write pointer is circular. lap_cnt = min(lap_cnt+1, LAP_DEPTH).
//   RECALL idx 0 = newest lap, lap_cnt-1 = oldest. Entry to RECALL sets idx=0.
//  Outputs: bcd/out combinational from registered time (norm=1) or lap[idx] (norm=0).
//   Change visible immediately after the updating posedge. running=(state==RUN).
// TESTING (TICK_DIV=4, LAP_DEPTH=2, MIN_MAX=100 unless stated)
//  reset, mode=1, enter pulse, 400 clk -> bcd=24'h000100, running=1, ovf=0
//  run 6 clk, enter, wait 50 clk, enter, 2 clk -> bcd=24'h000002 (partial tick kept)
//  esc laps at cs 5,10,15, enter, up -> norm=0, bcd=24'h000015; up -> 24'h000010;
//   up -> stays 24'h000010; down -> 24'h000015; esc -> norm=1, live value, lap_cnt=2
//  enter+esc same cycle in RUN -> PAUSE, lap_cnt unchanged; then esc -> bcd=0, lap_cnt=0
//  MIN_MAX=1, TICK_DIV=1: 6000 clk RUN -> 24'h000000 at 6000th tick, ovf=1 until clear
//  mode->0 mid-RUN -> bcd=0, running=0; rst_n low mid-RUN -> outputs to reset values async

Source files
------------

// File: rtl/lap_stopwatch.sv
// lap_stopwatch: MM:SS.cc stopwatch with a circular lap buffer,
// recall browsing while paused, and six 7-segment digit codes.

module bcd2seven (
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  // active-high {dp,g,f,e,d,c,b,a}; non-decimal codes blank
  always_comb begin
    case (bcd)
      4'd0:    seg = 8'h3F;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5B;
      4'd3:    seg = 8'h4F;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6D;
      4'd6:    seg = 8'h7D;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h6F;
      default: seg = 8'h00;
    endcase
  end

endmodule

module lap_stopwatch #(
  parameter int TICK_DIV  = 10000,
  parameter int LAP_DEPTH = 4,
  parameter int MIN_MAX   = 100
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mode,
  input  logic                           enter,
  input  logic                           esc,
  input  logic                           up,
  input  logic                           down,
  output logic [23:0]                    bcd,
  output logic [47:0]                    out,
  output logic                           norm,
  output logic                           running,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_cnt,
  output logic                           ovf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int CW = $clog2(LAP_DEPTH + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(LAP_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(LAP_DEPTH);
  localparam logic [6:0]    MIN_LAST = 7'(MIN_MAX - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    RECALL
  } state_t;

  state_t        state;
  logic          enter_q;
  logic          esc_q;
  logic          up_q;
  logic          down_q;
  logic          ev_enter;
  logic          ev_esc;
  logic          ev_up;
  logic          ev_down;
  logic          clr;
  logic [PW-1:0] pre_q;
  logic [6:0]    cs_q;
  logic [5:0]    sec_q;
  logic [6:0]    min_q;
  logic [19:0]   lap_mem [LAP_DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] rd_ptr;
  logic [19:0]   shown;

  function automatic logic [7:0] bcd2(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  // button history; tracks even when mode is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_q <= 1'b0;
      esc_q   <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      enter_q <= enter;
      esc_q   <= esc;
      up_q    <= up;
      down_q  <= down;
    end
  end

  // rising-edge events, one per cycle, enter > esc > up > down
  always_comb begin
    ev_enter = enter & ~enter_q;
    ev_esc   = esc & ~esc_q & ~ev_enter;
    ev_up    = up & ~up_q & ~ev_enter & ~ev_esc;
    ev_down  = down & ~down_q & ~ev_enter & ~ev_esc & ~ev_up;
    clr      = ~mode | ((state == PAUSE) & ev_esc);
  end

  // idx 0 is the entry just behind the write pointer
  always_comb begin
    int t;
    t = int'(wptr_q) + LAP_DEPTH - 1 - int'(idx_q);
    if (t >= LAP_DEPTH) t = t - LAP_DEPTH;
    rd_ptr = AW'(t);
  end

  // shown value: live time or the browsed lap
  always_comb begin
    shown = norm ? {min_q, sec_q, cs_q} : lap_mem[rd_ptr];
    bcd   = {bcd2(shown[19:13]),
             bcd2({1'b0, shown[12:7]}),
             bcd2(shown[6:0])};
  end

  for (genvar g = 0; g < 6; g++) begin : g_seg
    bcd2seven u_seg (
      .bcd (bcd[4*g +: 4]),
      .seg (out[8*g +: 8])
    );
  end

  // control FSM, timebase, lap buffer and registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pre_q   <= '0;
      cs_q    <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      wptr_q  <= '0;
      idx_q   <= '0;
      lap_cnt <= '0;
      ovf     <= 1'b0;
      norm    <= 1'b1;
      running <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++)
        lap_mem[i] <= '0;
    end else if (clr) begin
      state   <= IDLE;
      pre_q   <= '0;
      cs_q    <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      wptr_q  <= '0;
      idx_q   <= '0;
      lap_cnt <= '0;
      ovf     <= 1'b0;
      norm    <= 1'b1;
      running <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++)
        lap_mem[i] <= '0;
    end else begin
      if (state == RUN) begin
        if (pre_q == PRE_LAST) begin
          pre_q <= '0;
          if (cs_q == 7'd99) begin
            cs_q <= '0;
            if (sec_q == 6'd59) begin
              sec_q <= '0;
              if (min_q == MIN_LAST) begin
                min_q <= '0;
                ovf   <= 1'b1;
              end else begin
                min_q <= min_q + 7'd1;
              end
            end else begin
              sec_q <= sec_q + 6'd1;
            end
          end else begin
            cs_q <= cs_q + 7'd1;
          end
        end else begin
          pre_q <= pre_q + PW'(1);
        end
      end

      unique case (state)
        IDLE: begin
          if (ev_enter) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (ev_enter) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (ev_esc) begin
            lap_mem[wptr_q] <= {min_q, sec_q, cs_q};
            if (wptr_q == PTR_LAST) wptr_q <= '0;
            else wptr_q <= wptr_q + AW'(1);
            if (lap_cnt != CNT_FULL) lap_cnt <= lap_cnt + CW'(1);
          end
        end
        PAUSE: begin
          if (ev_enter) begin
            state   <= RUN;
            running <= 1'b1;
          end else if ((ev_up | ev_down) && lap_cnt != '0) begin
            state <= RECALL;
            idx_q <= '0;
            norm  <= 1'b0;
          end
        end
        RECALL: begin
          if (ev_enter | ev_esc) begin
            state <= PAUSE;
            norm  <= 1'b1;
          end else if (ev_up) begin
            if (CW'(idx_q) + CW'(1) < lap_cnt)
              idx_q <= idx_q + AW'(1);
          end else if (ev_down) begin
            if (idx_q != '0)
              idx_q <= idx_q - AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lap_stopwatch.sv
// tb_lap_stopwatch: scoreboard bench for lap_stopwatch,
// one instance at small divider and one at MIN_MAX=1.

module tb_lap_stopwatch;

  localparam int S_BCD1 = 0;
  localparam int S_OUT1 = 1;
  localparam int S_NRM1 = 2;
  localparam int S_RUN1 = 3;
  localparam int S_CNT1 = 4;
  localparam int S_OVF1 = 5;
  localparam int S_BCD2 = 6;
  localparam int S_OVF2 = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode1;
  logic        mode2;
  logic        enter;
  logic        esc;
  logic        up;
  logic        down;

  logic [23:0] bcd1;
  logic [47:0] out1;
  logic        norm1;
  logic        running1;
  logic [1:0]  lap_cnt1;
  logic        ovf1;

  logic [23:0] bcd2;
  logic [47:0] out2;
  logic        norm2;
  logic        running2;
  logic [1:0]  lap_cnt2;
  logic        ovf2;

  typedef struct {
    string       tag;
    int          sel;
    logic [47:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lap_stopwatch #(
    .TICK_DIV  (4),
    .LAP_DEPTH (2),
    .MIN_MAX   (100)
  ) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode1),
    .enter   (enter),
    .esc     (esc),
    .up      (up),
    .down    (down),
    .bcd     (bcd1),
    .out     (out1),
    .norm    (norm1),
    .running (running1),
    .lap_cnt (lap_cnt1),
    .ovf     (ovf1)
  );

  lap_stopwatch #(
    .TICK_DIV  (1),
    .LAP_DEPTH (2),
    .MIN_MAX   (1)
  ) u_dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode2),
    .enter   (enter),
    .esc     (esc),
    .up      (up),
    .down    (down),
    .bcd     (bcd2),
    .out     (out2),
    .norm    (norm2),
    .running (running2),
    .lap_cnt (lap_cnt2),
    .ovf     (ovf2)
  );

  task automatic check(input string tag,
                       input logic [47:0] obs,
                       input logic [47:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] probe(input int sel);
    case (sel)
      S_BCD1:  return {24'h0, bcd1};
      S_OUT1:  return out1;
      S_NRM1:  return {47'h0, norm1};
      S_RUN1:  return {47'h0, running1};
      S_CNT1:  return {46'h0, lap_cnt1};
      S_OVF1:  return {47'h0, ovf1};
      S_BCD2:  return {24'h0, bcd2};
      S_OVF2:  return {47'h0, ovf2};
      default: return 48'hx;
    endcase
  endfunction

  task automatic want(input int sel, input string tag,
                      input logic [47:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, probe(e.sel), e.val);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // {enter,esc,up,down} high for one edge, then one idle edge
  task automatic press(input logic [3:0] m);
    {enter, esc, up, down} = m;
    cyc(1);
    {enter, esc, up, down} = 4'b0000;
    cyc(1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    mode1 = 1'b1;
    mode2 = 1'b0;
    {enter, esc, up, down} = 4'b0000;
    #12;
    want(S_BCD1, "rst_bcd", 48'h0);
    want(S_OUT1, "rst_out", 48'h3F3F3F3F3F3F);
    want(S_NRM1, "rst_norm", 48'h1);
    want(S_RUN1, "rst_running", 48'h0);
    want(S_CNT1, "rst_lapcnt", 48'h0);
    want(S_OVF1, "rst_ovf", 48'h0);
    drain();
    rst_n = 1'b1;

    press(4'b1000);
    cyc(399);
    want(S_BCD1, "run400_bcd", 48'h000100);
    want(S_OUT1, "run400_out", 48'h3F3F3F063F3F);
    want(S_RUN1, "run400_running", 48'h1);
    want(S_OVF1, "run400_ovf", 48'h0);
    want(S_NRM1, "run400_norm", 48'h1);
    drain();

    rst_n = 1'b0;
    #2;
    want(S_BCD1, "async_bcd", 48'h0);
    want(S_OUT1, "async_out", 48'h3F3F3F3F3F3F);
    want(S_RUN1, "async_running", 48'h0);
    want(S_CNT1, "async_lapcnt", 48'h0);
    drain();
    #2;
    rst_n = 1'b1;

    press(4'b1000);
    cyc(5);
    press(4'b1000);
    cyc(49);
    want(S_BCD1, "pause_bcd", 48'h000001);
    want(S_RUN1, "pause_running", 48'h0);
    drain();
    press(4'b1000);
    cyc(1);
    want(S_BCD1, "resume_bcd", 48'h000002);
    want(S_RUN1, "resume_running", 48'h1);
    drain();

    pulse_reset();
    press(4'b1000);
    cyc(19);
    press(4'b0100);
    cyc(18);
    press(4'b0100);
    cyc(18);
    press(4'b0100);
    press(4'b1000);
    want(S_BCD1, "laps_live", 48'h000015);
    want(S_CNT1, "laps_sat", 48'h2);
    want(S_RUN1, "laps_paused", 48'h0);
    drain();
    press(4'b0010);
    want(S_NRM1, "rcl_norm", 48'h0);
    want(S_BCD1, "rcl_newest", 48'h000015);
    drain();
    press(4'b0010);
    want(S_BCD1, "rcl_older", 48'h000010);
    drain();
    press(4'b0010);
    want(S_BCD1, "rcl_sat_old", 48'h000010);
    drain();
    press(4'b0001);
    want(S_BCD1, "rcl_newer", 48'h000015);
    drain();
    press(4'b0001);
    want(S_BCD1, "rcl_sat_new", 48'h000015);
    drain();
    press(4'b0100);
    want(S_NRM1, "rcl_exit_norm", 48'h1);
    want(S_BCD1, "rcl_exit_bcd", 48'h000015);
    want(S_CNT1, "rcl_exit_cnt", 48'h2);
    drain();
    press(4'b0001);
    press(4'b1000);
    want(S_NRM1, "rcl_enter_norm", 48'h1);
    want(S_RUN1, "rcl_enter_run", 48'h0);
    drain();

    press(4'b1000);
    press(4'b1100);
    want(S_RUN1, "both_running", 48'h0);
    want(S_CNT1, "both_lapcnt", 48'h2);
    drain();
    press(4'b0100);
    want(S_BCD1, "clear_bcd", 48'h0);
    want(S_CNT1, "clear_lapcnt", 48'h0);
    want(S_NRM1, "clear_norm", 48'h1);
    drain();
    press(4'b1000);
    press(4'b1000);
    press(4'b0010);
    want(S_NRM1, "nolap_norm", 48'h1);
    drain();
    press(4'b0100);

    press(4'b1000);
    cyc(10);
    mode1 = 1'b0;
    cyc(1);
    want(S_BCD1, "mode0_bcd", 48'h0);
    want(S_RUN1, "mode0_running", 48'h0);
    drain();
    enter = 1'b1;
    cyc(2);
    mode1 = 1'b1;
    cyc(2);
    want(S_RUN1, "held_noevent", 48'h0);
    drain();
    enter = 1'b0;
    cyc(1);
    press(4'b1000);
    want(S_RUN1, "after_held", 48'h1);
    drain();

    mode1 = 1'b0;
    mode2 = 1'b1;
    cyc(1);
    press(4'b1000);
    cyc(5998);
    want(S_BCD2, "wrap_pre_bcd", 48'h005999);
    want(S_OVF2, "wrap_pre_ovf", 48'h0);
    drain();
    cyc(1);
    want(S_BCD2, "wrap_bcd", 48'h000000);
    want(S_OVF2, "wrap_ovf", 48'h1);
    drain();
    cyc(1);
    want(S_BCD2, "wrap_post_bcd", 48'h000001);
    want(S_OVF2, "wrap_sticky", 48'h1);
    drain();
    press(4'b1000);
    press(4'b0100);
    want(S_OVF2, "ovf_clear", 48'h0);
    want(S_BCD2, "ovf_clear_bcd", 48'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
